// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bit-counter width and bus levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUBAD,
        ST_SUBAD_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam int unsigned BIT_CNT_W = 4;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_slave_subad_if.sv
// Local-side port bundle of the sub-addressed I2C target: write strobe, read port, status.
interface i2c_slave_subad_if #(
    parameter int unsigned PTR_W = 6
);
    logic             wr_valid;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic [PTR_W-1:0] loc_addr;
    logic [7:0]       loc_data;
    logic             busy;

    modport slave (
        output wr_valid, wr_addr, wr_data, loc_data, busy,
        input  loc_addr
    );

    modport master (
        input  wr_valid, wr_addr, wr_data, loc_data, busy,
        output loc_addr
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge, START and STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise_c,
    output logic o_scl_fall_c,
    output logic o_sda_s,
    output logic o_start_det_c,
    output logic o_stop_det_c
);
    logic r_scl_meta, r_scl_sync, r_scl_d;
    logic r_sda_meta, r_sda_sync, r_sda_d;

    // Reset to the idle-bus level so no spurious edges follow reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_d    <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_d    <= r_sda_sync;
        end
    end

    assign o_sda_s       = r_sda_sync;
    assign o_scl_rise_c  =  r_scl_sync & ~r_scl_d;
    assign o_scl_fall_c  = ~r_scl_sync &  r_scl_d;
    assign o_start_det_c =  r_scl_sync &  r_scl_d & ~r_sda_sync &  r_sda_d;
    assign o_stop_det_c  =  r_scl_sync &  r_scl_d &  r_sda_sync & ~r_sda_d;

endmodule

// File: rtl/i2c_slave_subad.sv
// I2C target with an 8-bit sub-address pointer into a byte register file.
module i2c_slave_subad
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned DEPTH      = 34,
    parameter int unsigned PTR_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    inout  wire              sda,
    i2c_slave_subad_if.slave bus
);
    logic             w_scl_rise, w_scl_fall, w_sda_s, w_start, w_stop;
    logic [7:0]       w_byte;
    logic             w_last_bit;
    logic [PTR_W-1:0] w_ptr_next;

    state_t           r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]       r_shift;
    logic [PTR_W-1:0] r_ptr;
    logic [7:0]       r_mem [DEPTH];
    logic             r_rw;
    logic             r_sda_oe;
    logic             r_busy;
    logic             r_wr_valid;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;

    i2c_bus_sync u_sync (
        .clk           (clk),
        .rst           (rst),
        .i_scl         (scl),
        .i_sda         (sda),
        .o_scl_rise_c  (w_scl_rise),
        .o_scl_fall_c  (w_scl_fall),
        .o_sda_s       (w_sda_s),
        .o_start_det_c (w_start),
        .o_stop_det_c  (w_stop)
    );

    assign w_byte     = {r_shift[6:0], w_sda_s};
    assign w_last_bit = (r_bit_cnt == BIT_CNT_W'(7));
    assign w_ptr_next = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);

    // Open-drain pad: only ever pulls low
    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.loc_data = (32'(bus.loc_addr) < DEPTH) ? r_mem[bus.loc_addr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_rw       <= I2C_WRITE;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else begin
                // SDA only changes after SCL falls, and is held until the next fall
                if (w_scl_fall) begin
                    case (r_state)
                        ST_ADDR_ACK, ST_SUBAD_ACK, ST_WDATA_ACK: r_sda_oe <= 1'b1;
                        ST_RDATA: r_sda_oe <= ~r_shift[7];
                        default:  r_sda_oe <= 1'b0;
                    endcase
                end
                if (w_scl_rise) begin
                    r_shift   <= w_byte;
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                    case (r_state)
                        ST_ADDR: begin
                            if (w_last_bit) begin
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                        ST_ADDR_ACK: begin
                            r_bit_cnt <= '0;
                            if (r_rw == I2C_READ) begin
                                r_shift <= r_mem[r_ptr];
                                r_state <= ST_RDATA;
                            end else begin
                                r_state <= ST_SUBAD;
                            end
                        end
                        ST_SUBAD: begin
                            if (w_last_bit) begin
                                if (32'(w_byte) < DEPTH) begin
                                    r_ptr   <= PTR_W'(w_byte);
                                    r_state <= ST_SUBAD_ACK;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                        ST_SUBAD_ACK, ST_WDATA_ACK: begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_WDATA;
                            if (r_state == ST_WDATA_ACK) r_ptr <= w_ptr_next;
                        end
                        ST_WDATA: begin
                            if (w_last_bit) begin
                                r_mem[r_ptr] <= w_byte;
                                r_wr_valid   <= 1'b1;
                                r_wr_addr    <= r_ptr;
                                r_wr_data    <= w_byte;
                                r_state      <= ST_WDATA_ACK;
                            end
                        end
                        ST_RDATA: begin
                            r_shift <= {r_shift[6:0], 1'b0};
                            if (w_last_bit) r_state <= ST_RDATA_ACK;
                        end
                        ST_RDATA_ACK: begin
                            r_bit_cnt <= '0;
                            if (w_sda_s == ACK) begin
                                r_ptr   <= w_ptr_next;
                                r_shift <= r_mem[w_ptr_next];
                                r_state <= ST_RDATA;
                            end else if (w_sda_s == NACK) begin
                                r_state <= ST_IGNORE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
